// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : Issue controller between the instruction decoder and the
//               execute stage. Tracks pending register writes in a busy
//               bitmap and holds decoded instructions on RAW/WAW hazards,
//               when the outstanding-write limit is reached, or while a
//               drain is requested. Hazard-free instructions pass through
//               one register stage using a valid/stall handshake.
//
// Ports       : clk, rst (async, active-low)
//               Decoder side : valid_i, stall_o, opecode_i, rd_i, rs_i,
//                              immf_i, wr_en_i
//               Execute side : valid_o, stall_i, opecode_o, rd_o, rs_o,
//                              immf_o
//               Writeback    : wb_valid_i, wb_rd_i
//               Control      : drain_req_i, drain_done_o, outst_o, err_o
//
// Build option: SCOREBOARD_BYPASS_EN - when defined, a writeback in the
//               current cycle masks its register out of the hazard check so
//               a waiting instruction issues in the same cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
    parameter int LEN_REGNO   = 6,
    parameter int LEN_OPECODE = 7,
    parameter int MAX_OUTST   = 8,
    parameter int LEN_CNT     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    // decoder side
    input  logic                   valid_i,
    output logic                   stall_o,
    input  logic [LEN_OPECODE-1:0] opecode_i,
    input  logic [LEN_REGNO-1:0]   rd_i,
    input  logic [LEN_REGNO-1:0]   rs_i,
    input  logic                   immf_i,
    input  logic                   wr_en_i,
    // execute side
    output logic                   valid_o,
    input  logic                   stall_i,
    output logic [LEN_OPECODE-1:0] opecode_o,
    output logic [LEN_REGNO-1:0]   rd_o,
    output logic [LEN_REGNO-1:0]   rs_o,
    output logic                   immf_o,
    // writeback
    input  logic                   wb_valid_i,
    input  logic [LEN_REGNO-1:0]   wb_rd_i,
    // control / status
    input  logic                   drain_req_i,
    output logic                   drain_done_o,
    output logic [LEN_CNT-1:0]     outst_o,
    output logic                   err_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 c_num_regs  = 2 ** LEN_REGNO;
    localparam logic [LEN_CNT-1:0] c_max_outst = LEN_CNT'(MAX_OUTST);
    localparam logic [LEN_CNT-1:0] c_cnt_one   = LEN_CNT'(1);
    localparam logic [LEN_CNT-1:0] c_cnt_zero  = '0;

    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_drain = 1'b1;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    w_in_run;
    logic                    w_drain_done;

    logic [c_num_regs-1:0]   r_busy;
    logic [c_num_regs-1:0]   w_busy_nxt;
    logic [c_num_regs-1:0]   w_wb_mask;
    logic [c_num_regs-1:0]   w_busy_chk;

    logic [LEN_CNT-1:0]      r_outst;
    logic [LEN_CNT-1:0]      w_outst_nxt;
    logic                    r_err;

    logic                    r_valid;
    logic [LEN_OPECODE-1:0]  r_opecode;
    logic [LEN_REGNO-1:0]    r_rd;
    logic [LEN_REGNO-1:0]    r_rs;
    logic                    r_immf;

    logic                    w_hold;
    logic                    w_hazard;
    logic                    w_issue;
    logic                    w_set;
    logic                    w_wb_ok;
    logic                    w_wb_bad;
    logic                    w_at_limit;

    // ------------------------------------------------------------------
    // Busy view used by the hazard check. With bypass, a register being
    // written back this cycle already counts as free.
    // ------------------------------------------------------------------
`ifdef SCOREBOARD_BYPASS_EN
    localparam logic [c_num_regs-1:0] c_onehot_base = c_num_regs'(1);
    assign w_wb_mask = wb_valid_i ? (c_onehot_base << wb_rd_i) : '0;
`else
    assign w_wb_mask = '0;
`endif

    assign w_busy_chk = r_busy & ~w_wb_mask;

    // ------------------------------------------------------------------
    // Hazard / handshake
    // ------------------------------------------------------------------
    assign w_hold     = r_valid & stall_i;
    assign w_at_limit = (r_outst == c_max_outst);

    // rd_i is read as a source as well, so a busy rd always stalls,
    // whether or not the instruction writes it.
    assign w_hazard = valid_i & ( w_busy_chk[rd_i]
                                | (~immf_i & w_busy_chk[rs_i])
                                | (wr_en_i & w_at_limit)
                                | ~w_in_run );

    assign w_issue = valid_i & ~w_hazard & ~w_hold;
    assign stall_o = w_hold | w_hazard;

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    assign w_set    = w_issue & wr_en_i;
    // Writebacks are judged against the registered bitmap: a writeback to
    // a register that is only being set this cycle is a stray, and the set
    // is a fresh write that must stay pending.
    assign w_wb_ok  = wb_valid_i &  r_busy[wb_rd_i];
    assign w_wb_bad = wb_valid_i & ~r_busy[wb_rd_i];

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_ok) begin
            w_busy_nxt[wb_rd_i] = 1'b0;
        end
        // set after clear: a same-cycle set/clear of one register keeps it busy
        if (w_set) begin
            w_busy_nxt[rd_i] = 1'b1;
        end
    end

    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_set, w_wb_ok})
            2'b10:   w_outst_nxt = r_outst + c_cnt_one;
            2'b01:   w_outst_nxt = r_outst - c_cnt_one;
            default: w_outst_nxt = r_outst;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy  <= '0;
            r_outst <= c_cnt_zero;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_outst <= w_outst_nxt;
            r_err   <= r_err | w_wb_bad;
        end
    end

    // ------------------------------------------------------------------
    // Output pipeline register. Loads every cycle the execute stage is
    // not holding it; a hazard therefore produces a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_opecode <= '0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_immf    <= 1'b0;
        end else if (!w_hold) begin
            r_valid   <= w_issue;
            r_opecode <= opecode_i;
            r_rd      <= rd_i;
            r_rs      <= rs_i;
            r_immf    <= immf_i;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run: begin
                if (drain_req_i) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                // Leaving is allowed at any point, drained or not.
                if (!drain_req_i) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: w_state_nxt = c_st_run;
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        w_in_run     = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            c_st_run: begin
                w_in_run = 1'b1;
            end
            c_st_drain: begin
                w_drain_done = (r_outst == c_cnt_zero) & ~r_valid;
            end
            default: begin
                w_in_run = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign valid_o      = r_valid;
    assign opecode_o    = r_opecode;
    assign rd_o         = r_rd;
    assign rs_o         = r_rs;
    assign immf_o       = r_immf;
    assign outst_o      = r_outst;
    assign err_o        = r_err;
    assign drain_done_o = w_drain_done;

endmodule
`default_nettype wire
